uart_rx_fifo: RTL

//  Oversampling UART receiver with byte FIFO; front end for the CDH ground/debug serial link.

---
 rtl/uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a first-word-fall-through
// byte FIFO with a valid/ready consumer interface and sticky error flags.
// Optional feature: define UART_PARITY_EN for 8E1 frames and a parity_err output.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [ADDR_W:0] fifo_count,
  output logic            frame_err,
  output logic            overrun_err,
`ifdef UART_PARITY_EN
  output logic            parity_err,
`endif
  input  logic            err_clr
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_FW  = ADDR_W + 1;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e state_q, state_d;

  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_req;
  logic             frame_set;
`ifdef UART_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             par_set;
  logic             par_err_q, par_err_d;
`endif

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              pop, full, push_ok, overrun_set;

  // Receiver next-state: edge detect, mid-bit sampling, LSB-first shift.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
`ifdef UART_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF_M1)) begin
          cnt_d   = '0;
          state_d = rxd_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(FULL_M1)) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_W'(FULL_M1)) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ rxd_sync_q;
          par_set   = (^shift_q) ^ rxd_sync_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_W'(FULL_M1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rxd_sync_q) begin
`ifdef UART_PARITY_EN
            push_req = !par_bad_q;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO next-state: pointers, occupancy, fall-through head and error flags.
  always_comb begin
    pop         = rx_valid_q & rx_ready;
    full        = (count_q == CNT_FW'(DEPTH));
    push_ok     = push_req & (~full | pop);
    overrun_set = push_req & full & ~pop;
    wr_d        = push_ok ? wr_q + ADDR_W'(1) : wr_q;
    rd_d        = pop ? rd_q + ADDR_W'(1) : rd_q;
    count_d     = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_FW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_FW'(1);
    end
    rx_data_d = rx_data_q;
    if (count_d != '0) begin
      // A head sitting on the write slot is the byte being pushed right now.
      rx_data_d = (push_ok && (rd_d == wr_q)) ? shift_q : mem_q[rd_d];
    end
    rx_valid_d  = (count_d != '0);
    frame_err_d = frame_set | (frame_err_q & ~err_clr);
    overrun_d   = overrun_set | (overrun_q & ~err_clr);
`ifdef UART_PARITY_EN
    par_err_d   = par_set | (par_err_q & ~err_clr);
`endif
  end

  // State, synchroniser and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Byte storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= shift_q;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign fifo_count  = count_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_err  = par_err_q;
`endif

endmodule
